// File: rtl/spin_rate_ctrl.sv
// Speed-selectable step generator for a segment-spin animation, with
// debounced run/pause and direction pushbuttons.
module spin_rate_ctrl #(
    parameter int BASE_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic [1:0] spd,
    output logic       step,
    output logic       dir,
    output logic       running
);

    localparam int PW = $clog2(BASE_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [1:0]    btn_raw;
    logic [1:0]    press;
    logic [0:0]    state_reg;
    logic          dir_reg;
    logic          step_reg;
    logic [PW-1:0] pcnt_reg;
    logic [31:0]   period_full;
    logic [PW-1:0] period_m1;

    assign btn_raw = {btn_dir, btn_run};

    // Bit 0 = run button, bit 1 = direction button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          acc_reg;
            logic          acc_prev_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    acc_reg      <= 1'b1;
                    acc_prev_reg <= 1'b1;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    acc_prev_reg <= acc_reg;
                    if (sync2_reg != acc_reg) begin
                        if (cnt_reg == DB_LAST) begin
                            acc_reg <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            // Press = accepted level falling; release produces nothing.
            assign press[gi] = acc_prev_reg & ~acc_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            dir_reg   <= 1'b0;
        end else begin
            if (press[0]) begin
                case (state_reg)
                    ST_RUN:  state_reg <= ST_PAUSE;
                    default: state_reg <= ST_RUN;
                endcase
            end
            if (press[1]) begin
                dir_reg <= ~dir_reg;
            end
        end
    end

    assign period_full = 32'(BASE_DIV) >> spd;
    assign period_m1   = PW'(period_full - 32'd1);

    // >= rather than == so a sudden shorter period wraps immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg <= '0;
            step_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            if (pcnt_reg >= period_m1) begin
                pcnt_reg <= '0;
                step_reg <= 1'b1;
            end else begin
                pcnt_reg <= pcnt_reg + 1'b1;
                step_reg <= 1'b0;
            end
        end else begin
            step_reg <= 1'b0;
        end
    end

    assign step    = step_reg;
    assign dir     = dir_reg;
    assign running = (state_reg == ST_RUN);

endmodule

// File: tb/tb_spin_rate_ctrl.sv
// Directed self-checking bench for spin_rate_ctrl (BASE_DIV=16, DB_CYCLES=4).
module tb_spin_rate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b1;
    logic       btn_dir = 1'b1;
    logic [1:0] spd = 2'd0;
    logic       step;
    logic       dir;
    logic       running;

    int n_cmp = 0;
    int n_bad = 0;

    spin_rate_ctrl #(.BASE_DIV(16), .DB_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_dir (btn_dir),
        .spd     (spd),
        .step    (step),
        .dir     (dir),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] spd;
        int         period;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int c;

        vecs[0] = '{spd: 2'd0, period: 16};
        vecs[1] = '{spd: 2'd1, period: 8};
        vecs[2] = '{spd: 2'd2, period: 4};
        vecs[3] = '{spd: 2'd3, period: 2};

        // Reset state and first step latency
        do_reset();
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_running", int'(running), 1);
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("first_steps_e%0d", e), int'(step), int'(e == 16 || e == 32));
        end

        // Steady-state period per speed setting
        for (int i = 0; i < 4; i++) begin
            spd = vecs[i].spd;
            w = 0;
            while (step !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            check($sformatf("sync_spd%0d", vecs[i].spd), int'(step), 1);
            tick();
            check($sformatf("no_double_spd%0d", vecs[i].spd), int'(step), 0);
            c = 1;
            while (step !== 1'b1 && c < 40) begin
                tick();
                c++;
            end
            check($sformatf("period_spd%0d", vecs[i].spd), c, vecs[i].period);
        end

        // Speed change to a shorter period while pcnt = 10
        spd = 2'd0;
        do_reset();
        for (int e = 1; e <= 10; e++) tick();
        spd = 2'd3;
        tick();
        check("spdchg_step1", int'(step), 1);
        tick();
        check("spdchg_gap", int'(step), 0);
        tick();
        check("spdchg_step2", int'(step), 1);

        // Pause, idle while paused, resume from held count
        spd = 2'd0;
        do_reset();
        btn_run = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("pause_run_e%0d", e), int'(running), int'(e < 7));
            check($sformatf("pause_step_e%0d", e), int'(step), 0);
        end
        btn_run = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("paused_step_e%0d", e), int'(step), 0);
            check($sformatf("paused_run_e%0d", e), int'(running), 0);
        end
        btn_run = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 10) btn_run = 1'b1;
            check($sformatf("resume_run_e%0d", e), int'(running), int'(e >= 7));
            check($sformatf("resume_step_e%0d", e), int'(step), int'(e == 16));
        end

        // Short glitch on run button
        btn_run = 1'b0;
        for (int e = 1; e <= 3; e++) tick();
        btn_run = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check($sformatf("glitch_run_e%0d", e), int'(running), 1);
            check($sformatf("glitch_dir_e%0d", e), int'(dir), 0);
        end

        // Simultaneous presses toggle both on the same edge
        btn_run = 1'b0;
        btn_dir = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("both_run_e%0d", e), int'(running), int'(e < 7));
            check($sformatf("both_dir_e%0d", e), int'(dir), int'(e >= 7));
        end
        btn_run = 1'b1;
        btn_dir = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("both_rel_run_e%0d", e), int'(running), 0);
            check($sformatf("both_rel_dir_e%0d", e), int'(dir), 1);
        end

        // Reset in the middle of a direction debounce
        do_reset();
        btn_dir = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_db_rst_dir", int'(dir), 0);
        for (int e = 1; e <= 3; e++) tick();
        btn_dir = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check($sformatf("mid_db_dir_e%0d", e), int'(dir), 0);
            check($sformatf("mid_db_run_e%0d", e), int'(running), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
